dtim_arbiter: RTL and testbench

//  Two-port front end that sits directly upstream of the data tightly-integrated memory (dtim).

---
 rtl/dtim_arbiter_if.sv | 43 ++++
 rtl/dtim_arbiter.sv | 152 +++++++++++++++
 tb/tb_dtim_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtim_arbiter_if.sv
// dtim arbiter bus bundle: fetch, load/store and dtim request ports.
// slave = arbiter side, master = core/dtim side.
interface dtim_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_error;
  logic        dtim_valid;
  logic        dtim_instr;
  logic [31:0] dtim_addr;
  logic [31:0] dtim_wdata;
  logic [3:0]  dtim_wstrb;
  logic [31:0] dtim_rdata;
  logic        dtim_ready;

  modport slave (
    input  imem_valid, imem_addr,
    input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dtim_rdata, dtim_ready,
    output imem_rdata, imem_ready, imem_error,
    output dmem_rdata, dmem_ready, dmem_error,
    output dtim_valid, dtim_instr, dtim_addr,
    output dtim_wdata, dtim_wstrb
  );

  modport master (
    output imem_valid, imem_addr,
    output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output dtim_rdata, dtim_ready,
    input  imem_rdata, imem_ready, imem_error,
    input  dmem_rdata, dmem_ready, dmem_error,
    input  dtim_valid, dtim_instr, dtim_addr,
    input  dtim_wdata, dtim_wstrb
  );
endinterface

// File: rtl/dtim_arbiter.sv
// dtim front end: merges fetch and load/store ports onto one
// dtim request port, one transaction in flight, round-robin ties.
module dtim_arbiter #(
  parameter int TIMEOUT   = 256,
  parameter bit PRIO_DATA = 1'b1
) (
  input logic           clk,
  input logic           rst,
  dtim_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state;
  logic        own_d;
  logic        rr;
  logic [CW-1:0] cnt;
  logic        i_pend, d_pend;
  req_t        i_slot, d_slot;

  logic        i_new, d_new;
  logic        i_cand, d_cand;
  logic        tie;
  logic        gnt_i, gnt_d;
  logic        hit;
  req_t        i_req, d_req;

  // Candidate set, capture qualification and grant decision
  always_comb begin
    i_new  = bus.imem_valid & ~i_pend
           & ~((state == BUSY) & ~own_d);
    d_new  = bus.dmem_valid & ~d_pend
           & ~((state == BUSY) & own_d);
    i_req  = i_pend ? i_slot
                    : '{addr: bus.imem_addr,
                        wdata: 32'h0,
                        wstrb: 4'h0};
    d_req  = d_pend ? d_slot
                    : '{addr: bus.dmem_addr,
                        wdata: bus.dmem_wdata,
                        wstrb: bus.dmem_wstrb};
    i_cand = (state == IDLE) & (i_pend | i_new);
    d_cand = (state == IDLE) & (d_pend | d_new);
    tie    = i_cand & d_cand;
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    unique case (1'b1)
      tie: begin
        gnt_d = rr;
        gnt_i = ~rr;
      end
      i_cand & ~d_cand: gnt_i = 1'b1;
      d_cand & ~i_cand: gnt_d = 1'b1;
      default: ;
    endcase
    // The issue cycle does not count toward the timeout
    hit = (state == BUSY) & ~bus.dtim_valid
        & (cnt == TO_MAX);
  end

  // Slots, FSM, timeout counter and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      own_d          <= 1'b0;
      rr             <= PRIO_DATA;
      cnt            <= '0;
      i_pend         <= 1'b0;
      d_pend         <= 1'b0;
      i_slot         <= '0;
      d_slot         <= '0;
      bus.dtim_valid <= 1'b0;
      bus.dtim_instr <= 1'b0;
      bus.dtim_addr  <= 32'h0;
      bus.dtim_wdata <= 32'h0;
      bus.dtim_wstrb <= 4'h0;
      bus.imem_ready <= 1'b0;
      bus.imem_rdata <= 32'h0;
      bus.imem_error <= 1'b0;
      bus.dmem_ready <= 1'b0;
      bus.dmem_rdata <= 32'h0;
      bus.dmem_error <= 1'b0;
    end else begin
      bus.dtim_valid <= 1'b0;
      bus.imem_ready <= 1'b0;
      bus.imem_rdata <= 32'h0;
      bus.imem_error <= 1'b0;
      bus.dmem_ready <= 1'b0;
      bus.dmem_rdata <= 32'h0;
      bus.dmem_error <= 1'b0;

      if (i_new) begin
        i_pend <= 1'b1;
        i_slot <= i_req;
      end
      if (d_new) begin
        d_pend <= 1'b1;
        d_slot <= d_req;
      end
      if (gnt_i) i_pend <= 1'b0;
      if (gnt_d) d_pend <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gnt_i | gnt_d) begin
            state          <= BUSY;
            cnt            <= '0;
            own_d          <= gnt_d;
            bus.dtim_valid <= 1'b1;
            bus.dtim_instr <= gnt_i;
            bus.dtim_addr  <= gnt_d ? d_req.addr
                                    : i_req.addr;
            bus.dtim_wdata <= gnt_d ? d_req.wdata
                                    : i_req.wdata;
            bus.dtim_wstrb <= gnt_d ? d_req.wstrb
                                    : i_req.wstrb;
            if (tie) rr <= ~rr;
          end
        end
        BUSY: begin
          if (bus.dtim_ready | hit) begin
            state <= IDLE;
            if (own_d) begin
              bus.dmem_ready <= 1'b1;
              bus.dmem_rdata <= bus.dtim_ready
                              ? bus.dtim_rdata : 32'h0;
              bus.dmem_error <= ~bus.dtim_ready;
            end else begin
              bus.imem_ready <= 1'b1;
              bus.imem_rdata <= bus.dtim_ready
                              ? bus.dtim_rdata : 32'h0;
              bus.imem_error <= ~bus.dtim_ready;
            end
          end else if (!bus.dtim_valid && cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtim_arbiter.sv
// Scoreboard bench for dtim_arbiter: directed vectors push
// expected dtim requests and port responses; a monitor pops them.
module tb_dtim_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtim_arbiter_if bus ();

  dtim_arbiter #(
    .TIMEOUT   (TO),
    .PRIO_DATA (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          c;
    logic        ins;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_e_t;

  typedef struct {
    int          c;
    logic [31:0] rdata;
    logic        err;
  } rsp_e_t;

  req_e_t dq[$];
  rsp_e_t iq[$];
  rsp_e_t mq[$];

  task automatic tick();
    @(posedge clk);
    #1;
    bus.imem_valid = 1'b0;
    bus.dmem_valid = 1'b0;
    bus.dtim_ready = 1'b0;
    bus.dtim_rdata = 32'h0;
  endtask

  task automatic drive_i(input logic [31:0] a);
    bus.imem_valid = 1'b1;
    bus.imem_addr  = a;
  endtask

  task automatic drive_d(input logic [31:0] a,
                         input logic [31:0] w,
                         input logic [3:0]  s);
    bus.dmem_valid = 1'b1;
    bus.dmem_addr  = a;
    bus.dmem_wdata = w;
    bus.dmem_wstrb = s;
  endtask

  task automatic rsp(input logic [31:0] rd);
    bus.dtim_ready = 1'b1;
    bus.dtim_rdata = rd;
    tick();
  endtask

  task automatic exp_req(input int c, input logic ins,
                         input logic [31:0] a,
                         input logic [31:0] w,
                         input logic [3:0]  s);
    req_e_t e;
    e = '{c, ins, a, w, s};
    dq.push_back(e);
  endtask

  task automatic exp_i(input int c, input logic [31:0] rd,
                       input logic err);
    rsp_e_t e;
    e = '{c, rd, err};
    iq.push_back(e);
  endtask

  task automatic exp_d(input int c, input logic [31:0] rd,
                       input logic err);
    rsp_e_t e;
    e = '{c, rd, err};
    mq.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    logic [137:0] v;
    v = {bus.dtim_valid, bus.dtim_instr, bus.dtim_addr,
         bus.dtim_wdata, bus.dtim_wstrb,
         bus.imem_rdata, bus.imem_ready, bus.imem_error,
         bus.dmem_rdata, bus.dmem_ready, bus.dmem_error};
    n_chk++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h want 0", nm, v);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (bus.dtim_valid) begin
      req_e_t e;
      n_chk++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL dtim_req: unexpected at cyc %0d addr=%h",
                 cyc, bus.dtim_addr);
      end else begin
        e = dq.pop_front();
        if (e.c != cyc || e.ins !== bus.dtim_instr ||
            e.addr !== bus.dtim_addr ||
            e.wdata !== bus.dtim_wdata ||
            e.wstrb !== bus.dtim_wstrb) begin
          n_fail++;
          $display("FAIL dtim_req: got cyc=%0d ins=%b a=%h w=%h s=%h want cyc=%0d ins=%b a=%h w=%h s=%h",
                   cyc, bus.dtim_instr, bus.dtim_addr,
                   bus.dtim_wdata, bus.dtim_wstrb,
                   e.c, e.ins, e.addr, e.wdata, e.wstrb);
        end
      end
    end
    if (bus.imem_ready) begin
      rsp_e_t e;
      n_chk++;
      if (iq.size() == 0) begin
        n_fail++;
        $display("FAIL imem_rsp: unexpected at cyc %0d", cyc);
      end else begin
        e = iq.pop_front();
        if (e.c != cyc || e.rdata !== bus.imem_rdata ||
            e.err !== bus.imem_error) begin
          n_fail++;
          $display("FAIL imem_rsp: got cyc=%0d rd=%h err=%b want cyc=%0d rd=%h err=%b",
                   cyc, bus.imem_rdata, bus.imem_error,
                   e.c, e.rdata, e.err);
        end
      end
    end else begin
      n_chk++;
      if (bus.imem_rdata !== 32'h0 || bus.imem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL imem_idle: got rd=%h err=%b want 0",
                 bus.imem_rdata, bus.imem_error);
      end
    end
    if (bus.dmem_ready) begin
      rsp_e_t e;
      n_chk++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL dmem_rsp: unexpected at cyc %0d", cyc);
      end else begin
        e = mq.pop_front();
        if (e.c != cyc || e.rdata !== bus.dmem_rdata ||
            e.err !== bus.dmem_error) begin
          n_fail++;
          $display("FAIL dmem_rsp: got cyc=%0d rd=%h err=%b want cyc=%0d rd=%h err=%b",
                   cyc, bus.dmem_rdata, bus.dmem_error,
                   e.c, e.rdata, e.err);
        end
      end
    end else begin
      n_chk++;
      if (bus.dmem_rdata !== 32'h0 || bus.dmem_error !== 1'b0) begin
        n_fail++;
        $display("FAIL dmem_idle: got rd=%h err=%b want 0",
                 bus.dmem_rdata, bus.dmem_error);
      end
    end
  end

  initial begin
    int t;
    bus.imem_valid = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.dmem_valid = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
    bus.dmem_wstrb = 4'h0;
    bus.dtim_ready = 1'b0;
    bus.dtim_rdata = 32'h0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // single load
    t = cyc;
    drive_d(32'h40, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'h40, 32'h0, 4'h0);
    exp_d(t + 3, 32'hDEADBEEF, 1'b0);
    tick();
    tick();
    rsp(32'hDEADBEEF);
    tick();
    tick();

    // tie after reset: dmem first, then imem
    t = cyc;
    drive_i(32'h100);
    drive_d(32'h200, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'h200, 32'h0, 4'h0);
    exp_d(t + 3, 32'hA, 1'b0);
    exp_req(t + 4, 1'b1, 32'h100, 32'h0, 4'h0);
    exp_i(t + 5, 32'hB, 1'b0);
    tick();
    tick();
    rsp(32'hA);
    tick();
    rsp(32'hB);

    // next tie: imem first
    t = cyc;
    drive_i(32'h104);
    drive_d(32'h204, 32'h0, 4'h0);
    exp_req(t + 1, 1'b1, 32'h104, 32'h0, 4'h0);
    exp_i(t + 3, 32'hC, 1'b0);
    exp_req(t + 4, 1'b0, 32'h204, 32'h0, 4'h0);
    exp_d(t + 5, 32'hD, 1'b0);
    tick();
    tick();
    rsp(32'hC);
    tick();
    rsp(32'hD);
    tick();
    tick();

    // store held pending during a busy fetch
    t = cyc;
    drive_i(32'h300);
    exp_req(t + 1, 1'b1, 32'h300, 32'h0, 4'h0);
    tick();
    drive_d(32'h400, 32'h12345678, 4'hF);
    tick();
    tick();
    exp_i(t + 4, 32'h55, 1'b0);
    exp_req(t + 5, 1'b0, 32'h400, 32'h12345678, 4'hF);
    exp_d(t + 6, 32'h77, 1'b0);
    rsp(32'h55);
    tick();
    rsp(32'h77);
    tick();
    tick();

    // timeout, then pending fetch served
    t = cyc;
    drive_d(32'h500, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'h500, 32'h0, 4'h0);
    tick();
    drive_i(32'h600);
    exp_d(t + 10, 32'h0, 1'b1);
    exp_req(t + 11, 1'b1, 32'h600, 32'h0, 4'h0);
    exp_i(t + 12, 32'h66, 1'b0);
    repeat (10) tick();
    rsp(32'h66);
    tick();
    tick();

    // ready in the timeout cycle wins
    t = cyc;
    drive_d(32'hA00, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'hA00, 32'h0, 4'h0);
    exp_d(t + 10, 32'hCAFE, 1'b0);
    tick();
    repeat (8) tick();
    rsp(32'hCAFE);
    tick();
    tick();

    // reset mid-transaction, stale ready ignored
    t = cyc;
    drive_d(32'h700, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'h700, 32'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    tick();
    tick();
    check_zero("rst_hold");
    rst = 1'b1;
    tick();
    rsp(32'hBAD);
    tick();
    tick();
    check_zero("post_rst");
    t = cyc;
    drive_i(32'h800);
    exp_req(t + 1, 1'b1, 32'h800, 32'h0, 4'h0);
    exp_i(t + 3, 32'h88, 1'b0);
    tick();
    tick();
    rsp(32'h88);
    tick();

    // second request from the owner is dropped
    t = cyc;
    drive_d(32'h900, 32'h0, 4'h0);
    exp_req(t + 1, 1'b0, 32'h900, 32'h0, 4'h0);
    exp_d(t + 4, 32'h99, 1'b0);
    tick();
    drive_d(32'h904, 32'h0, 4'h0);
    tick();
    tick();
    rsp(32'h99);
    repeat (6) tick();

    n_chk++;
    if (dq.size() != 0 || iq.size() != 0 || mq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: left dtim=%0d imem=%0d dmem=%0d want 0",
               dq.size(), iq.size(), mq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
